presettable_counter_74x161: RTL and testbench

//  Parametrised synchronous presettable binary/modulo-N counter.

---
 rtl/presettable_counter_74x161.sv | 103 ++++++++++
 tb/tb_presettable_counter_74x161.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/presettable_counter_74x161.sv
// Synchronous presettable modulo-N counter with ENP/ENT cascade enables and ripple-carry output.
// Optional up/down counting (extra up_dn port) is enabled by defining COUNTER_74X161_UPDOWN_EN.
module presettable_counter_74x161 #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 2**WIDTH,
  parameter int RESET_VALUE = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
`ifdef COUNTER_74X161_UPDOWN_EN
  input  logic             up_dn,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);

  localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_EXT    = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP_VAL    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL    = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ZERO_VAL   = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH:0]   w_inc_ext;
  logic             w_up;
  logic             w_rco;

  // Increment one bit wider so q = 2**WIDTH-1 cannot alias back into range.
  function automatic logic [WIDTH-1:0] up_next(input logic [WIDTH:0] inc_ext);
    if (inc_ext >= MOD_EXT) begin
      up_next = ZERO_VAL;
    end else begin
      up_next = inc_ext[WIDTH-1:0];
    end
  endfunction

  // Out-of-range values (only reachable by load) re-enter at the top of the range.
  function automatic logic [WIDTH-1:0] down_next(input logic [WIDTH-1:0] cur);
    if ((cur == ZERO_VAL) || ({1'b0, cur} >= MOD_EXT)) begin
      down_next = TOP_VAL;
    end else begin
      down_next = cur - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef COUNTER_74X161_UPDOWN_EN
  assign w_up = up_dn;
`else
  assign w_up = 1'b1;
`endif

  assign w_inc_ext = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};

  // Count value and next-state selection: clear > load > count > hold.
  always_comb begin
    w_count = r_q;
    w_next  = r_q;
    if (w_up) begin
      w_count = up_next(w_inc_ext);
    end else begin
      w_count = down_next(r_q);
    end
    if (!clr_n) begin
      w_next = ZERO_VAL;
    end else if (!load_n) begin
      w_next = d;
    end else if (enp && ent) begin
      w_next = w_count;
    end else begin
      w_next = r_q;
    end
  end

  // Counter state register with asynchronous reset.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  // Terminal-count detect: exact equality only, so loaded out-of-range values never carry.
  always_comb begin
    w_rco = 1'b0;
    if (w_up) begin
      w_rco = ent && ({1'b0, r_q} == TOP_EXT);
    end else begin
      w_rco = ent && (r_q == ZERO_VAL);
    end
  end

  assign q   = r_q;
  assign rco = w_rco;

endmodule

// File: tb/tb_presettable_counter_74x161.sv
// Scoreboard bench for presettable_counter_74x161: decade, hex and a two-stage decade chain.
// Define COUNTER_74X161_UPDOWN_EN to also exercise down counting.
module tb_presettable_counter_74x161;

  logic       C = 1'b0;
  logic       R;
  logic       clr_n, load_n, enp, ent, up_dn, c_en;
  logic [3:0] d;
  logic [3:0] dec_q, hex_q, lo_q, hi_q;
  logic       dec_rco, hex_rco, lo_rco, hi_rco;

  typedef struct {
    int dq; int dr; int hq; int hr; int lq; int uq; int ur;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_dec, m_hex, m_cn;

  always #5 C = ~C;

  presettable_counter_74x161 #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dec (
    .C(C), .R(R), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
`ifdef COUNTER_74X161_UPDOWN_EN
    .up_dn(up_dn),
`endif
    .d(d), .q(dec_q), .rco(dec_rco));

  presettable_counter_74x161 #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) u_hex (
    .C(C), .R(R), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
`ifdef COUNTER_74X161_UPDOWN_EN
    .up_dn(up_dn),
`endif
    .d(d), .q(hex_q), .rco(hex_rco));

  presettable_counter_74x161 #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
    .C(C), .R(R), .clr_n(1'b1), .load_n(1'b1), .enp(c_en), .ent(c_en),
`ifdef COUNTER_74X161_UPDOWN_EN
    .up_dn(1'b1),
`endif
    .d(4'd0), .q(lo_q), .rco(lo_rco));

  presettable_counter_74x161 #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
    .C(C), .R(R), .clr_n(1'b1), .load_n(1'b1), .enp(1'b1), .ent(lo_rco),
`ifdef COUNTER_74X161_UPDOWN_EN
    .up_dn(1'b1),
`endif
    .d(4'd0), .q(hi_q), .rco(hi_rco));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_next(input int cur, input int m);
    if (!clr_n) return 0;
    if (!load_n) return int'(d);
    if (enp && ent) begin
      if (up_dn) return (cur >= m - 1) ? 0 : cur + 1;
      return (cur == 0 || cur >= m) ? m - 1 : cur - 1;
    end
    return cur;
  endfunction

  function automatic int model_rco(input int cur, input int m);
    if (!ent) return 0;
    if (up_dn) return (cur == m - 1) ? 1 : 0;
    return (cur == 0) ? 1 : 0;
  endfunction

  // One clock edge: predict, push, wait for the edge, pop and compare.
  task automatic step();
    exp_t e;
    if (R) begin
      m_dec = 0; m_hex = 0; m_cn = 0;
    end else begin
      m_dec = model_next(m_dec, 10);
      m_hex = model_next(m_hex, 16);
      if (c_en) m_cn = (m_cn + 1) % 100;
    end
    e.dq = m_dec; e.dr = model_rco(m_dec, 10);
    e.hq = m_hex; e.hr = model_rco(m_hex, 16);
    e.lq = m_cn % 10; e.uq = m_cn / 10;
    e.ur = (c_en && m_cn == 99) ? 1 : 0;
    sb.push_back(e);
    @(posedge C);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("dec_q", int'(dec_q), e.dq);
      chk("dec_rco", int'(dec_rco), e.dr);
      chk("hex_q", int'(hex_q), e.hq);
      chk("hex_rco", int'(hex_rco), e.hr);
      chk("lo_q", int'(lo_q), e.lq);
      chk("hi_q", int'(hi_q), e.uq);
      chk("hi_rco", int'(hi_rco), e.ur);
    end
  endtask

  initial begin
    R = 1'b0; clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    up_dn = 1'b1; c_en = 1'b0; d = 4'd0;
    m_dec = 0; m_hex = 0; m_cn = 0;
    #2 R = 1'b1;
    #1;
    chk("rst_dec_q", int'(dec_q), 0);
    chk("rst_dec_rco", int'(dec_rco), 0);
    chk("rst_hi_q", int'(hi_q), 0);
    @(negedge C);
    R = 1'b0;

    // Async reset mid-count, then held over three edges
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_q", int'(dec_q), 5);
    R = 1'b1;
    #2;
    chk("async_rst_q", int'(dec_q), 0);
    chk("async_rst_rco", int'(dec_rco), 0);
    chk("async_rst_hex", int'(hex_q), 0);
    for (int i = 0; i < 3; i++) step();
    R = 1'b0;

    // Free count: decade wraps 9->0, hex wraps 15->0
    for (int i = 0; i < 18; i++) step();

    // Priority
    load_n = 1'b0; d = 4'd7; step();
    chk("load_beats_count", int'(dec_q), 7);
    clr_n = 1'b0; step();
    chk("clr_beats_load", int'(dec_q), 0);
    clr_n = 1'b1; d = 4'd12; step();
    load_n = 1'b1;
    for (int i = 0; i < 2; i++) step();

    // Enables
    load_n = 1'b0; d = 4'd9; step();
    load_n = 1'b1; ent = 1'b0;
    #1 chk("rco_ent_low", int'(dec_rco), 0);
    for (int i = 0; i < 2; i++) step();
    enp = 1'b0; ent = 1'b1;
    #1 chk("rco_enp_low", int'(dec_rco), 1);
    for (int i = 0; i < 2; i++) step();
    enp = 1'b1;

    // Two-stage decade chain
    R = 1'b1; step(); R = 1'b0;
    c_en = 1'b1;
    for (int i = 0; i < 99; i++) step();
    chk("chain99_hi", int'(hi_q), 9);
    chk("chain99_lo", int'(lo_q), 9);
    chk("chain99_rco", int'(hi_rco), 1);
    step();
    chk("chain100_hi", int'(hi_q), 0);
    chk("chain100_lo", int'(lo_q), 0);
    c_en = 1'b0;

`ifdef COUNTER_74X161_UPDOWN_EN
    R = 1'b1; step(); R = 1'b0;
    up_dn = 1'b0;
    #1 chk("down_rco_at0", int'(dec_rco), 1);
    for (int i = 0; i < 3; i++) step();
    chk("down_q7", int'(dec_q), 7);
    load_n = 1'b0; d = 4'd13; step();
    load_n = 1'b1; step();
    chk("down_oor_to9", int'(dec_q), 9);
    load_n = 1'b0; d = 4'd5; step();
    load_n = 1'b1; up_dn = 1'b1; step();
    chk("toggle_up_q6", int'(dec_q), 6);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
